// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic int calc_clks_per_bit(input longint freq, input longint baud);
    return int'(freq / baud);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// N-stage synchronizer for the asynchronous serial line; resets to the idle level (1).
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with valid/ready output, parity/framing flags and sticky overrun.
// Optional feature: define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each bit centre.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_parity_err,
  output logic                 out_frame_err,
  output logic                 overrun,
  input  logic                 err_clr,
  output logic                 busy
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W        = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
  localparam int DECIDE_LAG = 1;
`else
  localparam int DECIDE_LAG = 0;
`endif

  // START decides at the half-bit point; every later decision is one full bit after the previous one.
  localparam logic [CNT_W-1:0] HALF_T   = CNT_W'(CLKS_PER_BIT / 2 + DECIDE_LAG);
  localparam logic [CNT_W-1:0] FULL_T   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 8) begin : g_chk_clks
    $error("uart_rx_param: CLOCK_FREQ/BAUD_RATE must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_rx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_chk_par
    $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_chk_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end

  logic rx_s;

  uart_rx_sync #(
    .STAGES(2)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d_i(uart_rx),
    .q_o(rx_s)
  );

  logic bit_s;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] is rx_s at the target count, hist_q[1] one cycle earlier; rx_s itself is target+1.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign bit_s = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
  assign bit_s = rx_s;
`endif

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 perr_out_q;
  logic                 ferr_out_q;
  logic                 overrun_q;
  logic                 busy_q;

  logic par_exp;
  logic ferr_d;

  assign par_exp = (^shift_q) ^ (PARITY_MODE == PAR_ODD);
  assign ferr_d  = ferr_q | ~bit_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
      // Cleared first so a same-cycle overrun below takes precedence.
      if (err_clr) begin
        overrun_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == HALF_T) begin
            cnt_q <= '0;
            if (bit_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= DATA;
              idx_q      <= '0;
              stop_idx_q <= 1'b0;
              perr_q     <= 1'b0;
              ferr_q     <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (cnt_q == FULL_T) begin
            cnt_q   <= '0;
            shift_q <= {bit_s, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              state_q <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        PARITY: begin
          if (cnt_q == FULL_T) begin
            cnt_q   <= '0;
            perr_q  <= bit_s ^ par_exp;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (cnt_q == FULL_T) begin
            cnt_q  <= '0;
            ferr_q <= ferr_d;
            if (STOP_BITS == 2 && !stop_idx_q) begin
              stop_idx_q <= 1'b1;
            end else begin
              // Back to IDLE at mid-stop so the next start edge is never missed.
              state_q <= IDLE;
              busy_q  <= 1'b0;
              if (!valid_q || out_ready) begin
                data_q     <= shift_q;
                perr_out_q <= perr_q;
                ferr_out_q <= ferr_d;
                valid_q    <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data       = data_q;
  assign out_valid      = valid_q;
  assign out_parity_err = perr_out_q;
  assign out_frame_err  = ferr_out_q;
  assign overrun        = overrun_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: three configurations (8N1, 8E2, 5O1) driven from frame-level tasks.
module tb_uart_rx_param;

  localparam int CF  = 1600000;
  localparam int BR  = 100000;
  localparam int CPB = 16;

  localparam int NB[3] = '{8, 8, 5};
  localparam int PM[3] = '{0, 1, 2};
  localparam int NS[3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_line;
  logic [2:0] rdy;
  logic       err_clr;

  logic [7:0] d0, d1;
  logic [4:0] d2;
  logic v0, pe0, fe0, ov0, b0;
  logic v1, pe1, fe1, ov1, b1;
  logic v2, pe2, fe2, ov2, b2;

  int tests = 0;
  int fails = 0;

  logic [10:0] q0[$];
  logic [10:0] q1[$];
  logic [10:0] q2[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst(rst), .uart_rx(rx_line[0]), .out_data(d0), .out_valid(v0), .out_ready(rdy[0]),
    .out_parity_err(pe0), .out_frame_err(fe0), .overrun(ov0), .err_clr(err_clr), .busy(b0));

  uart_rx_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .uart_rx(rx_line[1]), .out_data(d1), .out_valid(v1), .out_ready(rdy[1]),
    .out_parity_err(pe1), .out_frame_err(fe1), .overrun(ov1), .err_clr(err_clr), .busy(b1));

  uart_rx_param #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(5), .PARITY_MODE(2), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .uart_rx(rx_line[2]), .out_data(d2), .out_valid(v2), .out_ready(rdy[2]),
    .out_parity_err(pe2), .out_frame_err(fe2), .overrun(ov2), .err_clr(err_clr), .busy(b2));

  // Record every accepted word: {parity_err, frame_err, data zero-extended to 9 bits}.
  always @(negedge clk) begin
    if (v0 && rdy[0]) q0.push_back({pe0, fe0, 1'b0, d0});
    if (v1 && rdy[1]) q1.push_back({pe1, fe1, 1'b0, d1});
    if (v2 && rdy[2]) q2.push_back({pe2, fe2, 4'b0, d2});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int inst);
    case (inst)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpop(input int inst, output logic [10:0] w);
    case (inst)
      0:       w = q0.pop_front();
      1:       w = q1.pop_front();
      default: w = q2.pop_front();
    endcase
  endtask

  task automatic drive_bit(input int inst, input logic v, input logic glitch);
    rx_line[inst] = v;
    if (glitch) begin
      tick(8);
      rx_line[inst] = ~v;
      tick(1);
      rx_line[inst] = v;
      tick(CPB - 9);
    end else begin
      tick(CPB);
    end
  endtask

  // Serialise one frame: start, data LSB first, optional parity (optionally wrong), stop bit(s), idle gap.
  task automatic send_frame(input int inst, input logic [8:0] data, input logic par_flip,
                            input logic s1, input logic s2, input logic glitch);
    logic par;
    logic [8:0] m;
    m = data & 9'((1 << NB[inst]) - 1);
    drive_bit(inst, 1'b0, 1'b0);
    for (int i = 0; i < NB[inst]; i++) drive_bit(inst, m[i], glitch);
    if (PM[inst] != 0) begin
      par = ($countones(m) % 2) == 1;
      if (PM[inst] == 2) par = ~par;
      drive_bit(inst, par ^ par_flip, 1'b0);
    end
    drive_bit(inst, s1, 1'b0);
    if (NS[inst] == 2) drive_bit(inst, s2, 1'b0);
    rx_line[inst] = 1'b1;
    tick(2 * CPB);
  endtask

  task automatic get_word(input int inst, input string tag, output logic [10:0] w, output logic got);
    got = 1'b0;
    w   = '0;
    for (int i = 0; i < 400; i++) begin
      if (qsize(inst) > 0) begin
        got = 1'b1;
        break;
      end
      tick(1);
    end
    check({tag, "_delivered"}, 32'(got), 32'd1);
    if (got) qpop(inst, w);
  endtask

  task automatic frame_chk(input int inst, input string tag, input logic [8:0] data,
                           input logic par_flip, input logic s1, input logic s2, input logic glitch);
    logic [10:0] w;
    logic        got;
    logic [8:0]  exp_d;
    logic        exp_pe, exp_fe;
    exp_d  = data & 9'((1 << NB[inst]) - 1);
    exp_pe = (PM[inst] != 0) && par_flip;
    exp_fe = !s1 || (NS[inst] == 2 && !s2);
    send_frame(inst, data, par_flip, s1, s2, glitch);
    get_word(inst, tag, w, got);
    if (got) begin
      check({tag, "_data"}, 32'(w[8:0]), 32'(exp_d));
      check({tag, "_perr"}, 32'(w[10]), 32'(exp_pe));
      check({tag, "_ferr"}, 32'(w[9]), 32'(exp_fe));
      check({tag, "_single"}, 32'(qsize(inst)), 32'd0);
    end
  endtask

  initial begin
    logic [10:0] w;
    logic        got;
    logic [7:0]  partial;

    rst     = 1'b1;
    rx_line = 3'b111;
    rdy     = 3'b111;
    err_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_data", 32'(d0), 32'd0);
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_perr", 32'(pe0), 32'd0);
    check("rst_ferr", 32'(fe0), 32'd0);
    check("rst_overrun", 32'(ov0), 32'd0);
    check("rst_busy", 32'(b0), 32'd0);

    frame_chk(0, "a5", 9'h0A5, 1'b0, 1'b1, 1'b1, 1'b0);
    check("a5_busy_idle", 32'(b0), 32'd0);

    frame_chk(1, "p37_bad", 9'h037, 1'b1, 1'b1, 1'b1, 1'b0);
    frame_chk(1, "p37_good", 9'h037, 1'b0, 1'b1, 1'b1, 1'b0);

    frame_chk(0, "f55", 9'h055, 1'b0, 1'b0, 1'b1, 1'b0);
    frame_chk(0, "f0f", 9'h00F, 1'b0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      frame_chk(0, "rnd_8n1", 9'($urandom_range(255)), 1'b0, $urandom_range(3) != 0, 1'b1, 1'b0);
      frame_chk(1, "rnd_8e2", 9'($urandom_range(255)), 1'($urandom_range(1)),
                $urandom_range(3) != 0, $urandom_range(3) != 0, 1'b0);
      frame_chk(2, "rnd_5o1", 9'($urandom_range(31)), 1'($urandom_range(1)),
                $urandom_range(3) != 0, 1'b1, 1'b0);
    end

    // Stalled consumer: second word is dropped and overrun latches.
    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1, 1'b0);
    check("ovr_data_held", 32'(d0), 32'h11);
    check("ovr_valid", 32'(v0), 32'd1);
    check("ovr_flag", 32'(ov0), 32'd1);
    rdy[0] = 1'b1;
    tick(1);
    rdy[0] = 1'b0;
    tick(1);
    check("ovr_valid_drop", 32'(v0), 32'd0);
    get_word(0, "ovr_accept", w, got);
    if (got) check("ovr_accept_data", 32'(w[8:0]), 32'h11);
    check("ovr_sticky", 32'(ov0), 32'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("ovr_cleared", 32'(ov0), 32'd0);
    rdy[0] = 1'b1;

    // Short low glitch in idle must be rejected as a false start.
    rx_line[0] = 1'b0;
    tick(4);
    rx_line[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (!b0) break;
      tick(1);
    end
    check("glitch_busy", 32'(b0), 32'd0);
    tick(40);
    check("glitch_noword", 32'(qsize(0)), 32'd0);

`ifdef UART_RX_MAJORITY_EN
    frame_chk(0, "maj_c3", 9'h0C3, 1'b0, 1'b1, 1'b1, 1'b1);
`endif

    // Load a word and an overrun, then reset in the middle of a frame.
    rdy[0] = 1'b0;
    send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(0, 9'h06B, 1'b0, 1'b1, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(v0), 32'd1);
    partial = 8'h99;
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, partial[i], 1'b0);
    rst = 1'b1;
    rx_line[0] = 1'b1;
    tick(1);
    check("mid_rst_data", 32'(d0), 32'd0);
    check("mid_rst_valid", 32'(v0), 32'd0);
    check("mid_rst_perr", 32'(pe0), 32'd0);
    check("mid_rst_ferr", 32'(fe0), 32'd0);
    check("mid_rst_overrun", 32'(ov0), 32'd0);
    check("mid_rst_busy", 32'(b0), 32'd0);
    rdy[0] = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("post_rst_noword", 32'(qsize(0)), 32'd0);
    frame_chk(0, "post_rst_3c", 9'h03C, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver replacing the fixed 8N1 receiver in the ALU input path. Configurable data width, parity and stop bits. Adds an input synchronizer, a valid/ready output handshake, and per-word parity and framing error flags. A sticky overrun flag reports words lost while the consumer is stalled. Sits between the external serial line (Arduino link) and the ALU operand registers.

Parameters:
CLOCK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 115200, serial bit rate in baud
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY_MODE, 0, parity: 0 none, 1 even, 2 odd
STOP_BITS, 1, stop bits checked; legal values 1 or 2
(derived) CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE; elaboration error if < 8
(derived) CNT_W = $clog2(CLKS_PER_BIT+1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
uart_rx  in  1  asynchronous serial input; idle high
out_data  out  DATA_BITS  received payload, LSB = first bit on the line
out_valid  out  1  out_data and error flags valid
out_ready  in  1  consumer accepts the word when out_valid && out_ready
out_parity_err  out  1  parity mismatch on the held word (0 when PARITY_MODE=0)
out_frame_err  out  1  stop bit sampled 0 on the held word
overrun  out  1  sticky: a completed frame was dropped
err_clr  in  1  clears overrun (single-cycle pulse)
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: out_data 0, out_valid 0, both error flags 0, overrun 0, busy 0, FSM IDLE, synchronizer stages 1.
- uart_rx passes through a 2-FF synchronizer (rx_s). All sampling uses rx_s, which adds 2 cycles of latency.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on rx_s==0, go to START and clear the counter.
  - START: count to CLKS_PER_BIT/2 and resample. If rx_s==1, it is a false start: return to IDLE with no output. Otherwise clear the counter and bit index and go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, into the shift register. After bit DATA_BITS-1, go to PARITY if PARITY_MODE!=0, else go to STOP.
  - PARITY: sample one bit. Expected value is the XOR of the data bits for even parity, its inverse for odd parity. A mismatch sets an internal perr.
  - STOP: sample after CLKS_PER_BIT cycles. rx_s==0 sets an internal ferr. If STOP_BITS=2, sample a second stop bit after another CLKS_PER_BIT cycles; a 0 there also sets ferr. After the last stop sample, commit the word and return to IDLE in the same cycle. No wait for end of the stop bit, so back-to-back frames resynchronise.
- Commit: on the clock edge after the last stop sample, the holding register loads data, perr and ferr, and out_valid goes to 1.
- Handshake and overrun:
  - out_valid stays 1 until a cycle where out_ready=1.
  - Commit while out_valid=1 and out_ready=0: the new word is discarded, held data is unchanged, overrun is set to 1.
  - Commit in the same cycle as an accept: the new word is loaded, out_valid stays 1, no overrun.
  - err_clr clears overrun. If err_clr coincides with a new overrun event, the set wins.
- Counters: the bit counter wraps to 0 on every sample. Bit index width is $clog2(DATA_BITS). No counter runs in IDLE.
- Errors do not suppress delivery: errored words are still presented with their flags set.
- Reset mid-frame: the FSM and holding register clear immediately. Any partial frame is lost. If the line is low when reset releases, that is treated as a start bit.
- busy is 1 in every state except IDLE.

Optional Feature:
Macro: UART_RX_MAJORITY_EN
- Defined: each START, DATA, PARITY and STOP sample is the 2-of-3 majority of rx_s at counter values target-1, target and target+1. The decision is made at target+1, and the counter still wraps at CLKS_PER_BIT. This rejects a single-cycle glitch at mid-bit.
- Undefined: a single sample is taken at the target count.

Decomposition:
- Package uart_pkg:
  - state_t enum: IDLE, START, DATA, PARITY, STOP
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - function calc_clks_per_bit(freq, baud)
- Sub-module uart_rx_sync: parametrised N-stage synchronizer (default 2) with reset value 1.

Test Plan:
Configuration CLOCK_FREQ=1600000, BAUD_RATE=100000 (16 clk/bit), 8N1 unless noted.
1. Send 0xA5 with out_ready=1 -> one-cycle out_valid, out_data=0xA5, no error flags, busy back to 0.
2. PARITY_MODE=1, send 0x37 with parity bit 0 (expected 1) -> out_data=0x37, out_parity_err=1. Repeat with parity bit 1 -> out_parity_err=0.
3. Send 0x55 with stop bit held 0 -> out_frame_err=1, out_data=0x55. A following frame 0x0F -> flags clear.
4. out_ready=0, send 0x11 then 0x22 -> out_data stays 0x11, overrun=1. Pulse out_ready -> out_valid=0. Pulse err_clr -> overrun=0.
5. Low glitch of 4 cycles in IDLE -> no out_valid; busy drops to 0 within 10 cycles. With UART_RX_MAJORITY_EN, a 1-cycle inversion at mid-bit of 0xC3 -> 0xC3 still received.
6. Assert rst during DATA of 0x99 -> all outputs 0. Then send 0x3C -> out_data=0x3C with no errors.
